// File: rtl/power_estimator_pkg.sv
// Shared types and width helpers for the windowed power estimator.
package power_estimator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Accumulator width: a sum of 2^log2_win squares can never overflow it.
    function automatic int acc_width(input int data_w, input int log2_win);
        return 2 * data_w + log2_win;
    endfunction

endpackage

// File: rtl/power_estimator_if.sv
// Sample-in / power-out stream bundle between the sample source, the estimator and the capacity stage.
interface power_estimator_if #(
    parameter int DATA_W   = 16,
    parameter int LOG2_WIN = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [DATA_W-1:0] sig_sample;
    logic signed [DATA_W-1:0] noise_sample;
    logic                    out_valid;
    logic                    out_ready;
    logic [2*DATA_W-1:0]     s_pow;
    logic [2*DATA_W-1:0]     n_pow;
    logic                    n_zero;
    logic [LOG2_WIN-1:0]     win_count;

    modport master (
        output in_valid, sig_sample, noise_sample, out_ready,
        input  in_ready, out_valid, s_pow, n_pow, n_zero, win_count
    );

    modport slave (
        input  in_valid, sig_sample, noise_sample, out_ready,
        output in_ready, out_valid, s_pow, n_pow, n_zero, win_count
    );
endinterface

// File: rtl/power_estimator_square_reg.sv
// One-stage registered signed squarer with a valid bit; the square is always non-negative.
module square_reg #(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_valid,
    input  logic signed [DATA_W-1:0] i_sample,
    output logic                     o_valid,
    output logic [2*DATA_W-1:0]      o_square
);
    logic signed [2*DATA_W-1:0] w_ext;
    logic signed [2*DATA_W-1:0] w_product;
    logic                       r_valid;
    logic [2*DATA_W-1:0]        r_square;

    // (-2^(DATA_W-1))^2 = 2^(2*DATA_W-2) still fits the unsigned result.
    assign w_ext     = {{DATA_W{i_sample[DATA_W-1]}}, i_sample};
    assign w_product = w_ext * w_ext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_square <= '0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) r_square <= unsigned'(w_product);
        end
    end

    assign o_valid  = r_valid;
    assign o_square = r_square;
endmodule

// File: rtl/power_estimator.sv
// Windowed mean-square estimator: averages sig^2 and noise^2 over 2^LOG2_WIN accepted samples.
//   state | meaning
//   IDLE  | one cycle after reset, not yet accepting
//   ACCUM | accepting samples, counting the window
//   DRAIN | waiting for the last square to land in the accumulators
//   HOLD  | result presented until downstream takes it
module power_estimator
    import power_estimator_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int LOG2_WIN = 4
) (
    input  logic                clk,
    input  logic                reset,
    power_estimator_if.slave    bus
);
    localparam int ACC_W = acc_width(DATA_W, LOG2_WIN);
    localparam int PW    = 2 * DATA_W;
    localparam logic [LOG2_WIN-1:0] LAST = '1;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_in_ready;
    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_sq_valid_s;
    logic                w_sq_valid_n;
    logic                w_sq_valid;
    logic [PW-1:0]       w_sq_s;
    logic [PW-1:0]       w_sq_n;
    logic [ACC_W-1:0]    r_acc_s;
    logic [ACC_W-1:0]    r_acc_n;
    logic [LOG2_WIN-1:0] r_win_count;
    logic [PW-1:0]       r_s_pow;
    logic [PW-1:0]       r_n_pow;
    logic                r_n_zero;
    logic                r_out_valid;

    assign w_in_fire  = bus.in_valid && w_in_ready;
    assign w_out_fire = r_out_valid && bus.out_ready;
    assign w_sq_valid = w_sq_valid_s && w_sq_valid_n;

    square_reg #(.DATA_W(DATA_W)) u_sq_sig (
        .clk(clk), .reset(reset), .i_valid(w_in_fire), .i_sample(bus.sig_sample),
        .o_valid(w_sq_valid_s), .o_square(w_sq_s)
    );

    square_reg #(.DATA_W(DATA_W)) u_sq_noise (
        .clk(clk), .reset(reset), .i_valid(w_in_fire), .i_sample(bus.noise_sample),
        .o_valid(w_sq_valid_n), .o_square(w_sq_n)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  w_state_next = ST_ACCUM;
            ST_ACCUM: if (w_in_fire && r_win_count == LAST) w_state_next = ST_DRAIN;
            ST_DRAIN: if (!w_sq_valid) w_state_next = ST_HOLD;
            ST_HOLD:  if (w_out_fire) w_state_next = ST_ACCUM;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = (r_state == ST_ACCUM);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc_s     <= '0;
            r_acc_n     <= '0;
            r_win_count <= '0;
            r_s_pow     <= '0;
            r_n_pow     <= '0;
            r_n_zero    <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_in_fire) r_win_count <= r_win_count + 1'b1;

            if (r_state == ST_HOLD && w_out_fire) begin
                r_acc_s     <= '0;
                r_acc_n     <= '0;
                r_out_valid <= 1'b0;
            end else if (w_sq_valid) begin
                r_acc_s <= r_acc_s + ACC_W'(w_sq_s);
                r_acc_n <= r_acc_n + ACC_W'(w_sq_n);
            end

            // DRAIN exits only once the final square has been summed.
            if (r_state == ST_DRAIN && !w_sq_valid) begin
                r_s_pow     <= r_acc_s[ACC_W-1:LOG2_WIN];
                r_n_pow     <= r_acc_n[ACC_W-1:LOG2_WIN];
                r_n_zero    <= (r_acc_n[ACC_W-1:LOG2_WIN] == '0);
                r_out_valid <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.s_pow     = r_s_pow;
    assign bus.n_pow     = r_n_pow;
    assign bus.n_zero    = r_n_zero;
    assign bus.win_count = r_win_count;
endmodule

// File: tb/tb_power_estimator.sv
// Self-checking bench for power_estimator: directed scenarios plus random windows against a mean-square model.
module tb_power_estimator;
    localparam int DATA_W   = 16;
    localparam int LOG2_WIN = 4;
    localparam int WIN      = 1 << LOG2_WIN;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    power_estimator_if #(.DATA_W(DATA_W), .LOG2_WIN(LOG2_WIN)) ifc ();

    power_estimator #(.DATA_W(DATA_W), .LOG2_WIN(LOG2_WIN)) dut (
        .clk(clk), .reset(reset), .bus(ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: truncated mean of squares over one window.
    function automatic longint mean_sq(input int v[WIN]);
        longint sum = 0;
        for (int i = 0; i < WIN; i++) sum += longint'(v[i]) * longint'(v[i]);
        return sum / WIN;
    endfunction

    // All driving tasks start and end just after a falling edge.
    task automatic push_pair(input int s, input int n, input int gap_pct);
        int waited = 0;
        while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
            ifc.in_valid = 1'b0;
            @(negedge clk);
        end
        ifc.in_valid     = 1'b1;
        ifc.sig_sample   = 16'(s);
        ifc.noise_sample = 16'(n);
        while (ifc.in_ready !== 1'b1 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (ifc.in_ready !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL push_timeout: in_ready=%b after %0d cycles, required 1", ifc.in_ready, waited);
        end
        @(negedge clk);
        ifc.in_valid = 1'b0;
    endtask

    task automatic run_window(input int sv[WIN], input int nv[WIN], input int gap_pct);
        for (int i = 0; i < WIN; i++) push_pair(sv[i], nv[i], gap_pct);
    endtask

    task automatic wait_out(output bit got, output int edges);
        got = 1'b0;
        edges = 0;
        while (!got && edges < 40) begin
            if (ifc.out_valid === 1'b1) got = 1'b1;
            else begin
                @(negedge clk);
                edges++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ifc.in_valid = 1'b0; ifc.sig_sample = '0; ifc.noise_sample = '0; ifc.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (ifc.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b required 0", ifc.in_ready); end
            n_checks++; if (ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b required 0", ifc.out_valid); end
            n_checks++; if (ifc.s_pow !== 32'd0 || ifc.n_pow !== 32'd0) begin n_fail++; $display("FAIL rst_pow: got s=%0d n=%0d required 0 0", ifc.s_pow, ifc.n_pow); end
            n_checks++; if (ifc.n_zero !== 1'b0 || ifc.win_count !== 4'd0) begin n_fail++; $display("FAIL rst_flags: got n_zero=%b win=%0d required 0 0", ifc.n_zero, ifc.win_count); end
        end
        reset = 1'b0;
        #1;
        n_checks++; if (ifc.in_ready !== 1'b0) begin n_fail++; $display("FAIL rel_in_ready_early: got %b required 0", ifc.in_ready); end
        @(negedge clk);
        n_checks++; if (ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready: got %b required 1", ifc.in_ready); end
        ifc.out_ready = 1'b1;
    endtask

    task automatic test_basic();
        bit got; int edges;
        for (int i = 0; i < WIN; i++) begin
            n_checks++; if (ifc.win_count !== 4'(i)) begin n_fail++; $display("FAIL basic_win_count: got %0d required %0d", ifc.win_count, i); end
            push_pair(3, 1, 0);
        end
        n_checks++; if (ifc.win_count !== 4'd0) begin n_fail++; $display("FAIL basic_win_wrap: got %0d required 0", ifc.win_count); end
        n_checks++; if (ifc.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_drain_ready: got %b required 0", ifc.in_ready); end
        wait_out(got, edges);
        n_checks++; if (got !== 1'b1 || edges != 2) begin n_fail++; $display("FAIL basic_latency: got valid=%b after %0d edges required 1 after 2", got, edges); end
        n_checks++; if (ifc.s_pow !== 32'd9) begin n_fail++; $display("FAIL basic_s_pow: got %0d required 9", ifc.s_pow); end
        n_checks++; if (ifc.n_pow !== 32'd1) begin n_fail++; $display("FAIL basic_n_pow: got %0d required 1", ifc.n_pow); end
        n_checks++; if (ifc.n_zero !== 1'b0) begin n_fail++; $display("FAIL basic_n_zero: got %b required 0", ifc.n_zero); end
        @(negedge clk);
        n_checks++; if (ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle: out_valid got %b required 0", ifc.out_valid); end
        n_checks++; if (ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_reaccept: in_ready got %b required 1", ifc.in_ready); end
    endtask

    task automatic test_extreme();
        int sv[WIN]; int nv[WIN]; bit got; int edges;
        for (int i = 0; i < WIN; i++) begin sv[i] = -32768; nv[i] = 0; end
        run_window(sv, nv, 0);
        wait_out(got, edges);
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL ext_valid: got %b required 1", got); end
        n_checks++; if (ifc.s_pow !== 32'd1073741824) begin n_fail++; $display("FAIL ext_s_pow: got %0d required 1073741824", ifc.s_pow); end
        n_checks++; if (longint'(ifc.s_pow) != mean_sq(sv)) begin n_fail++; $display("FAIL ext_s_model: got %0d required %0d", ifc.s_pow, mean_sq(sv)); end
        n_checks++; if (ifc.n_pow !== 32'd0 || ifc.n_zero !== 1'b1) begin n_fail++; $display("FAIL ext_noise: got n=%0d z=%b required 0 1", ifc.n_pow, ifc.n_zero); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int sv[WIN]; int nv[WIN]; bit got; int edges;
        ifc.out_ready = 1'b0;
        for (int i = 0; i < WIN; i++) begin sv[i] = 5; nv[i] = 3; end
        run_window(sv, nv, 0);
        wait_out(got, edges);
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b required 1", got); end
        for (int c = 0; c < 10; c++) begin
            ifc.in_valid = 1'b1; ifc.sig_sample = 16'sd5; ifc.noise_sample = 16'sd3;
            @(negedge clk);
            n_checks++; if (ifc.out_valid !== 1'b1 || ifc.s_pow !== 32'd25 || ifc.n_pow !== 32'd9 || ifc.n_zero !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold c%0d: got v=%b s=%0d n=%0d z=%b required 1 25 9 0", c, ifc.out_valid, ifc.s_pow, ifc.n_pow, ifc.n_zero); end
            n_checks++; if (ifc.in_ready !== 1'b0 || ifc.win_count !== 4'd0) begin
                n_fail++; $display("FAIL bp_ignore c%0d: got ready=%b win=%0d required 0 0", c, ifc.in_ready, ifc.win_count); end
        end
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got v=%b ready=%b required 0 1", ifc.out_valid, ifc.in_ready); end
        n_checks++; if (ifc.s_pow !== 32'd25) begin n_fail++; $display("FAIL bp_keep_last: got %0d required 25", ifc.s_pow); end
        for (int i = 0; i < WIN; i++) begin sv[i] = 2; nv[i] = 2; end
        run_window(sv, nv, 0);
        wait_out(got, edges);
        n_checks++; if (got !== 1'b1 || ifc.s_pow !== 32'd4 || ifc.n_pow !== 32'd4) begin
            n_fail++; $display("FAIL bp_next_window: got v=%b s=%0d n=%0d required 1 4 4", got, ifc.s_pow, ifc.n_pow); end
        @(negedge clk);
    endtask

    task automatic test_truncation();
        int sv[WIN]; int nv[WIN]; bit got; int edges;
        for (int i = 0; i < WIN; i++) begin sv[i] = (i < WIN - 1) ? 1 : 0; nv[i] = 1; end
        run_window(sv, nv, 40);
        wait_out(got, edges);
        n_checks++; if (got !== 1'b1 || ifc.s_pow !== 32'd0) begin n_fail++; $display("FAIL trunc1_s_pow: got v=%b s=%0d required 1 0", got, ifc.s_pow); end
        n_checks++; if (ifc.n_pow !== 32'd1 || ifc.n_zero !== 1'b0) begin n_fail++; $display("FAIL trunc1_noise: got n=%0d z=%b required 1 0", ifc.n_pow, ifc.n_zero); end
        @(negedge clk);
        for (int i = 0; i < WIN; i++) begin sv[i] = (i < WIN / 2) ? 2 : 0; nv[i] = 0; end
        run_window(sv, nv, 20);
        wait_out(got, edges);
        n_checks++; if (got !== 1'b1 || ifc.s_pow !== 32'd2) begin n_fail++; $display("FAIL trunc2_s_pow: got v=%b s=%0d required 1 2", got, ifc.s_pow); end
        n_checks++; if (ifc.n_pow !== 32'd0 || ifc.n_zero !== 1'b1) begin n_fail++; $display("FAIL trunc2_noise: got n=%0d z=%b required 0 1", ifc.n_pow, ifc.n_zero); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int sv[WIN]; int nv[WIN]; bit got; int edges;
        logic signed [15:0] t;
        longint es; longint en;
        for (int w = 0; w < 4; w++) begin
            for (int i = 0; i < WIN; i++) begin
                t = 16'($urandom); sv[i] = int'(t);
                t = (w == 3) ? 16'(int'($urandom_range(3)) - 1) : 16'($urandom); nv[i] = int'(t);
            end
            es = mean_sq(sv);
            en = mean_sq(nv);
            run_window(sv, nv, 25);
            ifc.out_ready = 1'b0;
            wait_out(got, edges);
            repeat ($urandom_range(3)) @(negedge clk);
            n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_valid: got %b required 1", w, got); end
            n_checks++; if (longint'(ifc.s_pow) != es) begin n_fail++; $display("FAIL rnd%0d_s_pow: got %0d required %0d", w, ifc.s_pow, es); end
            n_checks++; if (longint'(ifc.n_pow) != en || ifc.n_zero !== (en == 0)) begin
                n_fail++; $display("FAIL rnd%0d_noise: got n=%0d z=%b required %0d %b", w, ifc.n_pow, ifc.n_zero, en, en == 0); end
            ifc.out_ready = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_window();
        bit got; int edges;
        for (int i = 0; i < 7; i++) push_pair(9, 9, 0);
        n_checks++; if (ifc.win_count !== 4'd7) begin n_fail++; $display("FAIL mid_partial: win_count got %0d required 7", ifc.win_count); end
        reset = 1'b1;
        #1;
        n_checks++; if (ifc.win_count !== 4'd0 || ifc.in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_async: got win=%0d ready=%b required 0 0", ifc.win_count, ifc.in_ready); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_restart: in_ready got %b required 1", ifc.in_ready); end
        for (int i = 0; i < WIN; i++) begin
            n_checks++; if (ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_early_valid at sample %0d: got %b required 0", i, ifc.out_valid); end
            push_pair(4, 2, 0);
        end
        wait_out(got, edges);
        n_checks++; if (got !== 1'b1 || edges != 2) begin n_fail++; $display("FAIL mid_latency: got valid=%b after %0d edges required 1 after 2", got, edges); end
        n_checks++; if (ifc.s_pow !== 32'd16 || ifc.n_pow !== 32'd4) begin n_fail++; $display("FAIL mid_pow: got s=%0d n=%0d required 16 4", ifc.s_pow, ifc.n_pow); end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_extreme();
        test_backpressure();
        test_truncation();
        test_random();
        test_reset_mid_window();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end
endmodule
